// File: rtl/lsu_mem_responder_if.sv
// Request/response bundle between the backend MEM stage (master) and the
// memory-side responder (slave) for the LSU opload/opstore channels.
interface lsu_mem_responder_if;
    logic        opload_index_valid;
    logic [18:0] opload_index;
    logic        opload_index_ready;
    logic [63:0] opload_read_data;
    logic        opload_operation_done;

    logic        opstore_index_valid;
    logic [18:0] opstore_index;
    logic        opstore_index_ready;
    logic [63:0] opstore_write_mask;
    logic [63:0] opstore_write_data;
    logic        opstore_operation_done;

    modport master (
        output opload_index_valid, opload_index,
        input  opload_index_ready, opload_read_data, opload_operation_done,
        output opstore_index_valid, opstore_index, opstore_write_mask, opstore_write_data,
        input  opstore_index_ready, opstore_operation_done
    );

    modport slave (
        input  opload_index_valid, opload_index,
        output opload_index_ready, opload_read_data, opload_operation_done,
        input  opstore_index_valid, opstore_index, opstore_write_mask, opstore_write_data,
        output opstore_index_ready, opstore_operation_done
    );
endinterface

// File: rtl/lsu_mem_responder.sv
// Single-outstanding LSU memory responder with a fixed-latency 64-bit word store.
// Define LSU_MEM_RSP_PERF_EN to add the perf_load_cnt / perf_store_cnt counters.
module lsu_mem_responder #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic clock,
    input  logic reset_n,
    lsu_mem_responder_if.slave bus
`ifdef LSU_MEM_RSP_PERF_EN
    ,
    output logic [31:0] perf_load_cnt,
    output logic [31:0] perf_store_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [3:0]  LAST_CNT  = 4'(LATENCY - 1);
    localparam logic [19:0] DEPTH_EXT = 20'(DEPTH);

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  cnt;
    logic        is_store_q;
    logic [18:0] idx_q;
    logic [63:0] mask_q;
    logic [63:0] data_q;
    logic [63:0] load_data_q;
    logic [63:0] mem [DEPTH];

    logic          accept;
    logic          finish;
    logic          in_range;
    logic [AW-1:0] word;

    assign accept   = (state == S_IDLE) && (bus.opstore_index_valid || bus.opload_index_valid);
    // finish marks the edge that enters DONE; all memory side effects happen there
    assign finish   = (state == S_WAIT) && (cnt == LAST_CNT);
    assign in_range = {1'b0, idx_q} < DEPTH_EXT;
    assign word     = idx_q[AW-1:0];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = S_WAIT;
            S_WAIT:  if (cnt == LAST_CNT) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        bus.opload_index_ready     = 1'b0;
        bus.opstore_index_ready    = 1'b0;
        bus.opload_operation_done  = 1'b0;
        bus.opstore_operation_done = 1'b0;
        case (state)
            S_IDLE: begin
                bus.opload_index_ready  = 1'b1;
                bus.opstore_index_ready = 1'b1;
            end
            S_DONE: begin
                bus.opload_operation_done  = !is_store_q;
                bus.opstore_operation_done = is_store_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt        <= 4'd0;
            is_store_q <= 1'b0;
        end else begin
            if (state == S_WAIT) begin
                cnt <= cnt + 4'd1;
            end else begin
                cnt <= 4'd0;
            end
            // store has priority; a simultaneous load stays pending at the inputs
            if (accept) begin
                is_store_q <= bus.opstore_index_valid;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (accept) begin
            idx_q  <= bus.opstore_index_valid ? bus.opstore_index : bus.opload_index;
            mask_q <= bus.opstore_write_mask;
            data_q <= bus.opstore_write_data;
        end
    end

    // Backing store is deliberately not reset so contents survive reset_n
    always_ff @(posedge clock) begin
        if (finish && is_store_q && in_range) begin
            mem[word] <= (mem[word] & ~mask_q) | (data_q & mask_q);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            load_data_q <= 64'h0;
        end else if (finish && !is_store_q) begin
            load_data_q <= in_range ? mem[word] : 64'h0;
        end
    end

    assign bus.opload_read_data = load_data_q;

`ifdef LSU_MEM_RSP_PERF_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            perf_load_cnt  <= 32'd0;
            perf_store_cnt <= 32'd0;
        end else if (finish) begin
            if (is_store_q) begin
                perf_store_cnt <= perf_store_cnt + 32'd1;
            end else begin
                perf_load_cnt <= perf_load_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_lsu_mem_responder.sv
// Scoreboard bench for lsu_mem_responder: directed stores/loads push expected
// completions; a negedge monitor checks type, cycle and data of every done pulse.
module tb_lsu_mem_responder;
    localparam int DEPTH = 1024;
    localparam int LAT   = 2;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    lsu_mem_responder_if bus();

`ifdef LSU_MEM_RSP_PERF_EN
    logic [31:0] perf_load_cnt;
    logic [31:0] perf_store_cnt;
`endif

    lsu_mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave)
`ifdef LSU_MEM_RSP_PERF_EN
        ,
        .perf_load_cnt  (perf_load_cnt),
        .perf_store_cnt (perf_store_cnt)
`endif
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        bit          is_store;
        logic [63:0] data;
        int          due;
    } exp_t;

    exp_t        sbq[$];
    int          checks = 0;
    int          fails  = 0;
    logic [63:0] last_load = 64'h0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clock) begin
        exp_t e;
        if (!reset_n) begin
            last_load = 64'h0;
        end else if (bus.opstore_operation_done || bus.opload_operation_done) begin
            check("done_onehot", 64'(bus.opstore_operation_done & bus.opload_operation_done), 64'd0);
            if (sbq.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                e = sbq.pop_front();
                check("done_type", 64'(bus.opstore_operation_done), 64'(e.is_store));
                check("done_cycle", 64'(cyc), 64'(e.due));
                if (!e.is_store) begin
                    check("load_data", bus.opload_read_data, e.data);
                    last_load = e.data;
                end else begin
                    check("load_data_held", bus.opload_read_data, last_load);
                end
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        @(negedge clock);
        while (!(bus.opstore_index_ready && bus.opload_index_ready) && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (n >= 50) check("ready_timeout", 64'd0, 64'd1);
    endtask

    task automatic check_busy();
        @(negedge clock);
        check("busy_ready", 64'({bus.opstore_index_ready, bus.opload_index_ready}), 64'd0);
    endtask

    task automatic do_store(input logic [18:0] idx, input logic [63:0] mask, input logic [63:0] data);
        exp_t e;
        wait_idle();
        bus.opstore_index_valid = 1'b1;
        bus.opstore_index       = idx;
        bus.opstore_write_mask  = mask;
        bus.opstore_write_data  = data;
        e.is_store = 1'b1;
        e.data     = 64'h0;
        e.due      = cyc + 1 + LAT;
        sbq.push_back(e);
        @(posedge clock);
        #1;
        bus.opstore_index_valid = 1'b0;
        bus.opstore_index       = ~idx;
        bus.opstore_write_mask  = ~mask;
        bus.opstore_write_data  = ~data;
        check_busy();
    endtask

    task automatic do_load(input logic [18:0] idx, input logic [63:0] expv);
        exp_t e;
        wait_idle();
        bus.opload_index_valid = 1'b1;
        bus.opload_index       = idx;
        e.is_store = 1'b0;
        e.data     = expv;
        e.due      = cyc + 1 + LAT;
        sbq.push_back(e);
        @(posedge clock);
        #1;
        bus.opload_index_valid = 1'b0;
        bus.opload_index       = ~idx;
        check_busy();
    endtask

    task automatic drain();
        int n = 0;
        while (sbq.size() != 0 && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (n >= 100) check("drain_timeout", 64'(sbq.size()), 64'd0);
        repeat (2) @(negedge clock);
    endtask

    task automatic pulse_reset();
        @(negedge clock);
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        check("rst_ready", 64'({bus.opstore_index_ready, bus.opload_index_ready}), 64'd3);
        check("rst_done", 64'({bus.opstore_operation_done, bus.opload_operation_done}), 64'd0);
        check("rst_read_data", bus.opload_read_data, 64'h0);
        reset_n = 1'b1;
    endtask

    initial begin
        exp_t e;
        bus.opload_index_valid  = 1'b0;
        bus.opload_index        = '0;
        bus.opstore_index_valid = 1'b0;
        bus.opstore_index       = '0;
        bus.opstore_write_mask  = '0;
        bus.opstore_write_data  = '0;

        // Reset state
        pulse_reset();

        // Basic store then load
        do_store(19'd5, {64{1'b1}}, 64'hDEADBEEF_CAFEF00D);
        do_load(19'd5, 64'hDEADBEEF_CAFEF00D);

        // Partial mask
        do_store(19'd7, {64{1'b1}}, 64'hFFFF_FFFF_FFFF_FFFF);
        do_store(19'd7, 64'h0000_0000_FFFF_0000, 64'h0);
        do_load(19'd7, 64'hFFFF_FFFF_0000_FFFF);

        // Simultaneous valids: store first, load accepted LAT+2 edges later
        wait_idle();
        bus.opstore_index_valid = 1'b1;
        bus.opstore_index       = 19'd3;
        bus.opstore_write_mask  = {64{1'b1}};
        bus.opstore_write_data  = 64'h11;
        bus.opload_index_valid  = 1'b1;
        bus.opload_index        = 19'd3;
        e.is_store = 1'b1; e.data = 64'h0;  e.due = cyc + 1 + LAT;
        sbq.push_back(e);
        e.is_store = 1'b0; e.data = 64'h11; e.due = cyc + 1 + LAT + LAT + 2;
        sbq.push_back(e);
        @(posedge clock);
        #1;
        bus.opstore_index_valid = 1'b0;
        bus.opstore_write_data  = 64'h99;
        repeat (LAT + 2) @(posedge clock);
        #1;
        bus.opload_index_valid = 1'b0;
        bus.opload_index       = 19'd5;
        drain();

        // Out of range accesses
        do_store(19'd0,    {64{1'b1}}, 64'hA0A0_A0A0_A0A0_A0A0);
        do_store(19'd1023, {64{1'b1}}, 64'h5151_5151_5151_5151);
        do_load(19'h400, 64'h0);
        do_store(19'h7FFFF, {64{1'b1}}, 64'h0BAD_0BAD_0BAD_0BAD);
        do_load(19'd0,    64'hA0A0_A0A0_A0A0_A0A0);
        do_load(19'd1023, 64'h5151_5151_5151_5151);
        drain();

        // Reset mid-WAIT abandons the store
        do_store(19'd9, {64{1'b1}}, 64'h0123_4567_89AB_CDEF);
        drain();
        wait_idle();
        bus.opstore_index_valid = 1'b1;
        bus.opstore_index       = 19'd9;
        bus.opstore_write_mask  = {64{1'b1}};
        bus.opstore_write_data  = 64'hFFFF_0000_FFFF_0000;
        @(posedge clock);
        #1;
        bus.opstore_index_valid = 1'b0;
        @(posedge clock);
        #1;
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        check("midrst_ready", 64'({bus.opstore_index_ready, bus.opload_index_ready}), 64'd3);
        check("midrst_done", 64'({bus.opstore_operation_done, bus.opload_operation_done}), 64'd0);
        reset_n = 1'b1;
        @(negedge clock);
        check("post_rst_ready", 64'({bus.opstore_index_ready, bus.opload_index_ready}), 64'd3);
        do_load(19'd9, 64'h0123_4567_89AB_CDEF);
        drain();

`ifdef LSU_MEM_RSP_PERF_EN
        pulse_reset();
        do_store(19'd20, {64{1'b1}}, 64'h20);
        do_store(19'd21, {64{1'b1}}, 64'h21);
        do_load(19'd20, 64'h20);
        do_load(19'd21, 64'h21);
        do_load(19'h500, 64'h0);
        drain();
        check("perf_load_cnt", 64'(perf_load_cnt), 64'd3);
        check("perf_store_cnt", 64'(perf_store_cnt), 64'd2);
        pulse_reset();
        check("perf_load_rst", 64'(perf_load_cnt), 64'd0);
        check("perf_store_rst", 64'(perf_store_cnt), 64'd0);
`endif

        drain();
        check("queue_empty", 64'(sbq.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
